instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC SHALL be: RESET_PC, default 32'h0000_0000, PC value loaded on reset (word-aligned).
REQ-002 Port i_clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port i_arst SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-004 Port i_redirect SHALL be: input, 1 bit, single-cycle pulse requesting a PC change (branch/jump).
REQ-005 Port i_redirectPc SHALL be: input, 32 bits, redirect target, sampled when i_redirect=1.
REQ-006 Port o_imemValid SHALL be: output, 1 bit, instruction-memory read request valid.
REQ-007 Port i_imemReady SHALL be: input, 1 bit, memory accepts the request.
REQ-008 Port o_imemAddr SHALL be: output, 32 bits, request byte address.
REQ-009 Port i_imemRspValid SHALL be: input, 1 bit, read data valid.
REQ-010 Port i_imemRspData SHALL be: input, 32 bits, fetched instruction word.
REQ-011 Port o_instrValid SHALL be: output, 1 bit, instruction presented downstream.
REQ-012 Port i_instrReady SHALL be: input, 1 bit, downstream consumes the instruction.
REQ-013 Port o_instr SHALL be: output, 32 bits, held instruction word.
REQ-014 Port o_operand SHALL be: output, 7 bits, o_instr[6:0], opcode for the controller.
REQ-015 Port o_pc SHALL be: output, 32 bits, address of the held instruction.
REQ-016 Port o_pcPlus4 SHALL be: output, 32 bits, o_pc + 4, modulo 2^32.
REQ-017 Port o_misalign SHALL be: output, 1 bit, one-cycle pulse flagging a rejected redirect.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT and HOLD; IDLE SHALL be left unconditionally to REQ one cycle after reset deasserts.
REQ-019 In REQ: o_imemValid=1 and o_imemAddr=PC; on i_imemReady=1 the FSM SHALL go to WAIT.
REQ-020 o_imemAddr SHALL remain stable while o_imemValid=1 and i_imemReady=0.
REQ-021 In WAIT: on i_imemRspValid=1 the FSM SHALL capture i_imemRspData into o_instr and go to HOLD.
REQ-022 In HOLD: o_instrValid=1; on i_instrReady=1 the FSM SHALL set PC=PC+4, wrapping from 32'hFFFF_FFFC to 0, and go to REQ.
REQ-023 o_instrValid SHALL be 0 in every state other than HOLD; o_instr, o_pc and o_operand SHALL be stable throughout HOLD.
REQ-024 A redirect with i_redirectPc[1:0]!=0 SHALL be ignored and SHALL assert o_misalign for exactly one cycle.
REQ-025 Aligned redirect in IDLE: PC SHALL be loaded with the target.
REQ-026 Aligned redirect in REQ without handshake: the target SHALL be stored as pending, the current request SHALL complete unchanged, and a flush flag SHALL be set.
REQ-027 Aligned redirect in REQ with i_imemReady=1 in the same cycle: the target SHALL be stored as pending and the flush flag SHALL be set.
REQ-028 Aligned redirect in WAIT: the target SHALL be stored as pending and the flush flag SHALL be set.
REQ-029 Aligned redirect in HOLD: the instruction SHALL be dropped, PC SHALL equal the target, and the FSM SHALL go to REQ; this SHALL take priority over a simultaneous i_instrReady.
REQ-030 With the flush flag set, the next response SHALL be discarded without entering HOLD; PC SHALL take the pending target, the flag SHALL clear, and the FSM SHALL go to REQ.
REQ-031 A later redirect while a target is pending SHALL overwrite the pending target.
REQ-032 Responses arriving outside WAIT SHALL be ignored.
REQ-033 The block SHALL have at most one outstanding request.

Reset
REQ-034 While i_arst=1 the block SHALL hold: state=IDLE, PC=RESET_PC, o_instr=32'h0000_0013 (NOP), flush flag=0, pending target=0.
REQ-035 While i_arst=1 the outputs SHALL be: o_imemValid=0, o_instrValid=0, o_misalign=0.
REQ-036 Reset asserted mid-transaction SHALL abandon the outstanding request; a response arriving after reset deasserts SHALL be ignored by the IDLE-state rule.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the NOP encoding constant, and the opcode constants LW=7'b0000011 and SW=7'b0100011, shared with the controller.
REQ-038 The PC register and its +4 and redirect mux SHALL be one sub-module, pc_reg; all other logic SHALL be flat.

Verification
REQ-039 Reset-release test: release reset with ready and rspValid tied high -> first o_imemAddr=0; o_instr=32'h00002083 (LW) appears with o_pc=0 and o_operand=7'b0000011.
REQ-040 Backpressure test: hold i_imemReady=0 for 5 cycles -> o_imemAddr stays constant; i_instrReady=0 for 3 cycles -> o_instr, o_pc held; afterwards o_pc=4.
REQ-041 Redirect-in-WAIT test: redirect to 32'h100 during WAIT -> response discarded, never valid downstream; next o_imemAddr=32'h100.
REQ-042 HOLD priority test: redirect to 32'h200 with i_instrReady=1 in HOLD -> next o_imemAddr=32'h200, not PC+4.
REQ-043 Misaligned-redirect test: redirect to 32'h102 -> o_misalign pulses for 1 cycle and the sequential fetch continues.
REQ-044 Wrap and mid-fetch reset test: RESET_PC=32'hFFFF_FFFC -> second fetch address is 0; reset asserted in WAIT -> outputs zero immediately and the late response is ignored.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: FSM state encoding, NOP word and the opcodes
// the controller decodes from o_operand.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [6:0]  OP_LW     = 7'b0000011;
  localparam logic [6:0]  OP_SW     = 7'b0100011;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter with sequential +4 step and redirect load.
// A load has priority over an increment; +4 wraps naturally modulo 2^32.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        incr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  // PC update: redirect target, else sequential step, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= target;
    else if (incr) pc <= pc_plus4;
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit. The PC doubles as the request
// address and as the address of the held instruction, so it only moves when
// a request is not in flight (IDLE, end of WAIT, or leaving HOLD). Redirects
// arriving while a request is in flight are parked and the response that
// comes back is dropped (flush).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_imemValid,
  input  logic        i_imemReady,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemRspValid,
  input  logic [31:0] i_imemRspData,
  output logic        o_instrValid,
  input  logic        i_instrReady,
  output logic [31:0] o_instr,
  output logic [6:0]  o_operand,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  output logic        o_misalign
);

  fetch_state_t state, state_nxt;

  logic [31:0] pc, pc_plus4, pc_tgt;
  logic [31:0] pend_pc, instr;
  logic        flush, flush_nxt;
  logic        pend_wr, pc_load, pc_incr, capture;
  logic        misalign;
  logic        redirect_ok, redirect_bad;

  assign redirect_ok  = i_redirect && (i_redirectPc[1:0] == 2'b00);
  assign redirect_bad = i_redirect && (i_redirectPc[1:0] != 2'b00);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (i_clk),
    .rst      (i_arst),
    .load     (pc_load),
    .target   (pc_tgt),
    .incr     (pc_incr),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // FSM state register
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, PC control and redirect bookkeeping
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_incr   = 1'b0;
    pc_tgt    = i_redirectPc;
    pend_wr   = 1'b0;
    flush_nxt = flush;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        pc_load   = redirect_ok;
      end
      REQ: begin
        // request address stays put; redirect only takes effect after the
        // in-flight request returns
        if (redirect_ok) begin
          pend_wr   = 1'b1;
          flush_nxt = 1'b1;
        end
        if (i_imemReady) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect_ok) begin
          pend_wr   = 1'b1;
          flush_nxt = 1'b1;
        end
        if (i_imemRspValid) begin
          if (redirect_ok) begin
            // redirect lands with the response: drop it, jump directly
            pc_load   = 1'b1;
            flush_nxt = 1'b0;
            state_nxt = REQ;
          end else if (flush) begin
            pc_load   = 1'b1;
            pc_tgt    = pend_pc;
            flush_nxt = 1'b0;
            state_nxt = REQ;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // redirect wins over consumption of the held instruction
        if (redirect_ok) begin
          pc_load   = 1'b1;
          flush_nxt = 1'b0;
          state_nxt = REQ;
        end else if (i_instrReady) begin
          pc_incr   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction, pending-target, flush and misalign registers
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      instr    <= NOP_INSTR;
      pend_pc  <= 32'h0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      if (capture) instr <= i_imemRspData;
      if (pend_wr) pend_pc <= i_redirectPc;
      flush    <= flush_nxt;
      misalign <= redirect_bad;
    end
  end

  assign o_imemValid  = (state == REQ);
  assign o_imemAddr   = pc;
  assign o_instrValid = (state == HOLD);
  assign o_instr      = instr;
  assign o_operand    = instr[6:0];
  assign o_pc         = pc;
  assign o_pcPlus4    = pc_plus4;
  assign o_misalign   = misalign;

endmodule
